// File: rtl/sram_port_arbiter.sv
// Two-cycle grant/response arbiter sharing one synchronous SRAM port between
// instruction fetch and the memory stage, with fixed kseg address translation.
module sram_port_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          inst_req_i,
  input  logic [AW-1:0] inst_addr_i,
  output logic          inst_ack_o,
  output logic [DW-1:0] inst_rdata_o,
  input  logic          data_req_i,
  input  logic [3:0]    data_wen_i,
  input  logic [AW-1:0] data_addr_i,
  input  logic [DW-1:0] data_wdata_i,
  output logic          data_ack_o,
  output logic [DW-1:0] data_rdata_o,
  output logic          sram_en_o,
  output logic [3:0]    sram_wen_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [DW-1:0] sram_wdata_o,
  input  logic [DW-1:0] sram_rdata_i
);

  localparam logic [AW-1:0] PhysMask = AW'(32'h1fff_ffff);

  typedef enum logic [1:0] {StIdle, StRespI, StRespD} state_e;

  state_e state_q, state_d;
  logic   last_data_q, last_data_d;
  logic   grant_data, grant_inst;

  // Data wins contention unless it also took the previous grant.
  assign grant_data = data_req_i & (~inst_req_i | ~last_data_q);
  assign grant_inst = inst_req_i & ~grant_data;

  always_comb begin
    state_d      = state_q;
    last_data_d  = last_data_q;
    inst_ack_o   = 1'b0;
    inst_rdata_o = '0;
    data_ack_o   = 1'b0;
    data_rdata_o = '0;
    sram_en_o    = 1'b0;
    sram_wen_o   = 4'h0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    unique case (state_q)
      StIdle: begin
        if (grant_data) begin
          sram_en_o    = 1'b1;
          sram_wen_o   = data_wen_i;
          sram_addr_o  = data_addr_i & PhysMask;
          sram_wdata_o = data_wdata_i;
          state_d      = StRespD;
          last_data_d  = 1'b1;
        end else if (grant_inst) begin
          sram_en_o    = 1'b1;
          sram_addr_o  = inst_addr_i & PhysMask;
          state_d      = StRespI;
          last_data_d  = 1'b0;
        end
      end
      StRespI: begin
        inst_ack_o   = 1'b1;
        inst_rdata_o = sram_rdata_i;
        state_d      = StIdle;
      end
      StRespD: begin
        data_ack_o   = 1'b1;
        data_rdata_o = sram_rdata_i;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Outputs stay quiet for the whole reset interval, even with requests high.
    if (!rst_ni) begin
      inst_ack_o   = 1'b0;
      inst_rdata_o = '0;
      data_ack_o   = 1'b0;
      data_rdata_o = '0;
      sram_en_o    = 1'b0;
      sram_wen_o   = 4'h0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      last_data_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the single synchronous data SRAM port between the instruction-fetch and memory-stage requesters of the MIPS core. Each access runs a two-cycle grant/response sequence. Data requests win contention unless data was also granted last, in which case fetch wins. Addresses are translated to physical form with the fixed kseg mask before reaching the SRAM. The block sits between the fetch stage / memory-stage store logic and the `sram_*` pins.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `clk`  in  1  rising-edge clock
- `resetn`  in  1  asynchronous, active-low reset
- `inst_req`  in  1  fetch request; held high until `inst_ack`
- `inst_addr`  in  AW  fetch virtual address; stable while `inst_req`
- `inst_ack`  out  1  one-cycle response strobe for fetch
- `inst_rdata`  out  DW  fetched word; valid only with `inst_ack`, else 0
- `data_req`  in  1  memory-stage request; held high until `data_ack`
- `data_wen`  in  4  byte write enables; 0 means read
- `data_addr`  in  AW  data virtual address
- `data_wdata`  in  DW  store data, already lane-shifted
- `data_ack`  out  1  one-cycle response strobe for data
- `data_rdata`  out  DW  load word; valid only with `data_ack`, else 0
- `sram_en`  out  1  SRAM access enable
- `sram_wen`  out  4  SRAM byte write enables
- `sram_addr`  out  AW  physical address, equal to `addr & 32'h1fffffff`
- `sram_wdata`  out  DW  SRAM write data
- `sram_rdata`  in  DW  SRAM read data, valid the cycle after `sram_en`

## Operation
- FSM states:
  - IDLE: issues a grant when a request is pending.
  - RESP_I: returns the fetch response.
  - RESP_D: returns the data response.
- `last_data` register: 1 means the previous grant went to data.
- Grant rule in IDLE:
  - Only one requester high: that requester is granted.
  - Both high: data is granted if `last_data`=0, fetch if `last_data`=1.
- Grant cycle (IDLE with a request):
  - `sram_en`=1.
  - Address, wen and wdata are driven from the granted requester.
  - Fetch grants drive `sram_wen`=0.
  - Next state: RESP_I or RESP_D.
  - `last_data` is updated to the granted side.
- RESP_x cycle:
  - `x_ack`=1 and `x_rdata`=`sram_rdata`.
  - `sram_en`=0.
  - Next state is always IDLE; no new grant is issued in a RESP state.
- Writes also take the RESP_D cycle. `data_ack` is asserted and `data_rdata` is don't-care (driven with `sram_rdata`).
- The requester samples the ack. A request still high in the IDLE cycle that follows the ack is treated as a new request.
- All `sram_*` outputs are 0 whenever no grant is being issued.

## Timing
- Latency: request seen in IDLE at cycle N, SRAM enable at N, ack at N+1.
- Peak throughput: one access per 2 cycles. Under both-requesters-high, grants alternate D, I, D, I.
- Reset (`resetn`=0, asynchronous):
  - State goes to IDLE and `last_data` goes to 0.
  - All outputs are forced to 0 for the whole reset interval, regardless of requests.
- Reset asserted during RESP_x: that ack is suppressed, and the access is lost (the requester reissues).
- First request after reset release is granted on the first rising edge-qualified IDLE cycle.
- A request dropped before ack (protocol violation) does not abort the sequence; the ack still issues.
- Acks are never simultaneous; `inst_ack & data_ack` is always 0.

## Test plan
- Single fetch: `inst_req`=1, `inst_addr`=0xBFC00000.
  - Cycle 0: `sram_en`=1, `sram_addr`=0x1FC00000, `sram_wen`=0.
  - Cycle 1: `inst_ack`=1 and `inst_rdata` equals SRAM data 0x3C1D8000.
- Store word: `data_req`=1, `data_wen`=0xF, `data_addr`=0x80001234, `data_wdata`=0xDEADBEEF.
  - `sram_addr`=0x00001234 and `sram_wen`=0xF in the grant cycle.
  - `data_ack` one cycle later.
- Contention: both requests held high for 8 cycles after reset.
  - Grants go D, I, D, I.
  - `data_ack` at cycles 1 and 5, `inst_ack` at cycles 3 and 7.
  - The acks are never coincident.
- Byte store lane: `data_wen`=0x4 with `data_wdata`=0x00AB0000.
  - `sram_wen`=0x4 and `sram_wdata` is passed unchanged.
- Reset mid-response: assert `resetn`=0 during RESP_D.
  - `data_ack` stays 0 and all `sram_*` outputs are 0.
  - After release with `inst_req` high, fetch is granted first.
- Idle: no requests for 10 cycles; all outputs stay 0 and the state stays IDLE.
